// File: rtl/iq_upsampler.sv
// iq_upsampler: baseband TX stage placed after the symbol mapper.
// Accepts one packed I/Q symbol per input beat, scales it by a signed Q2.14 gain
// (round half up, saturate to 16 bits) and expands it into Lq output samples,
// either zero-stuffed or sample-and-hold. The input TLAST is moved onto the final
// output sample of that symbol.
//
// Ports:
//   clk_bb_i      baseband clock, rising edge
//   rst_i         synchronous active-high reset
//   cfg_l_i       upsample factor (0 -> 1, above MAX_L -> MAX_L)
//   cfg_hold_i    0 = zero-stuff, 1 = sample-and-hold
//   cfg_gain_i    signed Q2.14 gain, 0x4000 = unity
//   sat_clr_i     clears the sticky saturation flag
//   in_valid_i / in_ready_o / in_data_i / in_last_i      symbol input (I = [31:16], Q = [15:0])
//   out_valid_o / out_ready_i / out_data_o / out_last_o  sample output
//   sat_flag_o    sticky: some scaled I or Q component was clamped
module iq_upsampler #(
  parameter int unsigned MAX_L = 16,
  parameter int unsigned LW    = 5
) (
  input  logic          clk_bb_i,
  input  logic          rst_i,
  input  logic [LW-1:0] cfg_l_i,
  input  logic          cfg_hold_i,
  input  logic [15:0]   cfg_gain_i,
  input  logic          sat_clr_i,
  input  logic          in_valid_i,
  output logic          in_ready_o,
  input  logic [31:0]   in_data_i,
  input  logic          in_last_i,
  output logic          out_valid_o,
  input  logic          out_ready_i,
  output logic [31:0]   out_data_o,
  output logic          out_last_o,
  output logic          sat_flag_o
);

  typedef enum logic [0:0] {StIdle, StEmit} state_e;

  localparam logic [LW-1:0] MaxLq = LW'(MAX_L);

  state_e        state_q;
  logic [LW-1:0] ph_q;
  logic [LW-1:0] lq_q;
  logic          hold_q;
  logic          last_q;
  logic [31:0]   sym_q;
  logic          sat_q;

  logic [LW-1:0] lq_in;
  logic [16:0]   scaled_i;
  logic [16:0]   scaled_q;
  logic          last_ph;
  logic          out_fire;
  logic          accept;
  logic          sat_d;

  // Returns {clamped, value}. |p| <= 2^30, so the rounding add cannot overflow.
  function automatic logic [16:0] scale_comp(input logic signed [15:0] x,
                                             input logic signed [15:0] g);
    logic signed [31:0] p;
    logic signed [31:0] r;
    p = 32'(x) * 32'(g);
    r = (p + 32'sd8192) >>> 14;
    if (r > 32'sd32767) begin
      return {1'b1, 16'h7fff};
    end else if (r < -32'sd32768) begin
      return {1'b1, 16'h8000};
    end else begin
      return {1'b0, r[15:0]};
    end
  endfunction

  always_comb begin
    lq_in = cfg_l_i;
    if (cfg_l_i == '0) begin
      lq_in = LW'(1);
    end else if (32'(cfg_l_i) > MAX_L) begin
      lq_in = MaxLq;
    end
  end

  always_comb begin
    scaled_i = scale_comp(in_data_i[31:16], cfg_gain_i);
    scaled_q = scale_comp(in_data_i[15:0], cfg_gain_i);
  end

  always_comb begin
    out_valid_o = (state_q == StEmit);
    last_ph     = (ph_q == lq_q - LW'(1));
    out_fire    = out_valid_o && out_ready_i;
    // A new symbol may enter in the same cycle the previous final sample leaves.
    in_ready_o  = !rst_i && ((state_q == StIdle) || (out_fire && last_ph));
    accept      = in_valid_i && in_ready_o;
    out_data_o  = (out_valid_o && ((ph_q == '0) || hold_q)) ? sym_q : 32'h0;
    out_last_o  = out_valid_o && last_q && last_ph;
    sat_flag_o  = sat_q;
  end

  // A fresh saturation takes priority over a simultaneous clear.
  always_comb begin
    sat_d = sat_q;
    if (sat_clr_i) begin
      sat_d = 1'b0;
    end
    if (accept && (scaled_i[16] || scaled_q[16])) begin
      sat_d = 1'b1;
    end
  end

  always_ff @(posedge clk_bb_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      ph_q    <= '0;
      lq_q    <= LW'(1);
      hold_q  <= 1'b0;
      last_q  <= 1'b0;
      sym_q   <= '0;
      sat_q   <= 1'b0;
    end else begin
      sat_q <= sat_d;
      // Symbol parameters are latched only on acceptance, so later cfg changes
      // never touch the symbol being emitted.
      if (accept) begin
        sym_q  <= {scaled_i[15:0], scaled_q[15:0]};
        lq_q   <= lq_in;
        hold_q <= cfg_hold_i;
        last_q <= in_last_i;
      end
      unique case (state_q)
        StIdle: begin
          if (accept) begin
            state_q <= StEmit;
            ph_q    <= '0;
          end
        end
        StEmit: begin
          if (out_fire) begin
            if (!last_ph) begin
              ph_q <= ph_q + LW'(1);
            end else if (accept) begin
              ph_q <= '0;
            end else begin
              state_q <= StIdle;
              ph_q    <= '0;
            end
          end
        end
        default: begin
          state_q <= StIdle;
          ph_q    <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_iq_upsampler.sv
// Scoreboard bench for iq_upsampler: the driver pushes hand-computed expected
// samples when it issues a symbol; an independent monitor pops and compares on
// every output transfer and checks AXIS stability while stalled.
module tb_iq_upsampler;

  logic        clk;
  logic        rst;
  logic [4:0]  cfg_l;
  logic        cfg_hold;
  logic [15:0] cfg_gain;
  logic        sat_clr;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        in_last;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        out_last;
  logic        sat_flag;

  int total = 0;
  int bad   = 0;
  int n_out = 0;

  logic [32:0] exp_q[$];

  iq_upsampler #(.MAX_L(16), .LW(5)) dut (
    .clk_bb_i   (clk),
    .rst_i      (rst),
    .cfg_l_i    (cfg_l),
    .cfg_hold_i (cfg_hold),
    .cfg_gain_i (cfg_gain),
    .sat_clr_i  (sat_clr),
    .in_valid_i (in_valid),
    .in_ready_o (in_ready),
    .in_data_i  (in_data),
    .in_last_i  (in_last),
    .out_valid_o(out_valid),
    .out_ready_i(out_ready),
    .out_data_o (out_data),
    .out_last_o (out_last),
    .sat_flag_o (sat_flag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Monitor: scoreboard pops, stall stability, in_ready while stalled.
  logic        prev_stall = 1'b0;
  logic [32:0] prev_out;
  always @(negedge clk) begin
    if (!rst) begin
      if (prev_stall) begin
        chk("stall_valid", 64'(out_valid), 64'd1);
        chk("stall_stable", 64'({out_last, out_data}), 64'(prev_out));
      end
      if (out_valid && !out_ready) begin
        chk("in_ready_stalled", 64'(in_ready), 64'd0);
      end
      if (out_valid && out_ready) begin
        n_out++;
        if (exp_q.size() == 0) begin
          chk("unexpected_out", 64'({out_last, out_data}), 64'h1_dead_beef);
        end else begin
          logic [32:0] e;
          e = exp_q.pop_front();
          chk("sample", 64'({out_last, out_data}), 64'(e));
        end
      end
    end
    prev_stall = !rst && out_valid && !out_ready;
    prev_out   = {out_last, out_data};
  end

  // Issue one symbol; push n expected samples built from the hand-computed scaled value.
  task automatic send(input logic [31:0] d, input logic last, input logic [4:0] l,
                      input logic hold, input logic [15:0] gain, input logic [31:0] scaled,
                      input int n, output int stalls);
    logic r;
    for (int i = 0; i < n; i++) begin
      logic [31:0] v;
      v = (i == 0 || hold) ? scaled : 32'h0;
      exp_q.push_back({last && (i == n - 1), v});
    end
    cfg_l = l; cfg_hold = hold; cfg_gain = gain;
    in_data = d; in_last = last; in_valid = 1'b1;
    stalls = 0;
    forever begin
      @(negedge clk);
      r = in_ready;
      @(posedge clk);
      if (r) break;
      stalls++;
      if (stalls > 200) begin
        chk("send_timeout", 64'(stalls), 64'd0);
        break;
      end
    end
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int c;
    c = 0;
    while (exp_q.size() != 0 && c < 200) begin
      @(posedge clk);
      c++;
    end
    chk("drain", 64'(exp_q.size()), 64'd0);
    @(posedge clk); #1;
  endtask

  int st;
  int st_sum;
  int n_before;
  logic [5:0] bp_pat;

  initial begin
    rst = 1'b1; cfg_l = 5'd1; cfg_hold = 1'b0; cfg_gain = 16'h4000; sat_clr = 1'b0;
    in_valid = 1'b0; in_data = '0; in_last = 1'b0; out_ready = 1'b1;
    bp_pat = 6'b101001;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_data", 64'(out_data), 64'd0);
    chk("rst_out_last", 64'(out_last), 64'd0);
    chk("rst_sat_flag", 64'(sat_flag), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    chk("in_ready_after_rst", 64'(in_ready), 64'd1);
    @(posedge clk); #1;

    // Zero-stuff L=4: 1000 / -1000 at unity
    send(32'h03E8_FC18, 1'b1, 5'd4, 1'b0, 16'h4000, 32'h03E8_FC18, 4, st);
    drain();

    // Hold L=3, gain 0.5: 20000 / -20000 -> 10000 / -10000
    send(32'h4E20_B1E0, 1'b0, 5'd3, 1'b1, 16'h2000, 32'h2710_D8F0, 3, st);
    drain();

    // L above MAX_L clamps to 16 samples
    send(32'h0064_FF9C, 1'b1, 5'd20, 1'b1, 16'h4000, 32'h0064_FF9C, 16, st);
    drain();

    // Saturation
    chk("sat_before", 64'(sat_flag), 64'd0);
    send(32'h7530_8AD0, 1'b0, 5'd1, 1'b0, 16'h7FFF, 32'h7FFF_8000, 1, st);
    chk("sat_set", 64'(sat_flag), 64'd1);
    sat_clr = 1'b1;
    @(posedge clk); #1;
    sat_clr = 1'b0;
    chk("sat_cleared", 64'(sat_flag), 64'd0);
    sat_clr = 1'b1;
    send(32'h7530_8AD0, 1'b0, 5'd1, 1'b0, 16'h7FFF, 32'h7FFF_8000, 1, st);
    sat_clr = 1'b0;
    chk("sat_wins_clr", 64'(sat_flag), 64'd1);
    drain();

    // Backpressure: 3 symbols at L=2 with out_ready pattern 1,0,0,1,0,1
    fork
      begin
        send(32'h0001_0002, 1'b0, 5'd2, 1'b1, 16'h4000, 32'h0001_0002, 2, st);
        send(32'h0003_0004, 1'b0, 5'd2, 1'b0, 16'h4000, 32'h0003_0004, 2, st);
        send(32'h0005_0006, 1'b1, 5'd2, 1'b1, 16'h4000, 32'h0005_0006, 2, st);
      end
      begin
        for (int i = 0; i < 18; i++) begin
          out_ready = bp_pat[i % 6];
          @(posedge clk); #1;
        end
        out_ready = 1'b1;
      end
    join
    drain();

    // Streaming L=1: 8 symbols back to back, no bubbles
    st_sum = 0;
    n_before = n_out;
    for (int i = 0; i < 8; i++) begin
      logic [31:0] v;
      v = {16'(i * 100), 16'(-(i * 7))};
      send(v, (i == 7), 5'd1, 1'b0, 16'h4000, v, 1, st);
      st_sum += st;
    end
    @(negedge clk); #1;
    chk("stream_stalls", 64'(st_sum), 64'd0);
    chk("stream_outputs", 64'(n_out - n_before), 64'd8);
    drain();

    // Streaming with L=0 treated as 1
    st_sum = 0;
    for (int i = 0; i < 4; i++) begin
      logic [31:0] v;
      v = {16'(-(i * 3 + 1)), 16'(i * 11)};
      send(v, (i == 3), 5'd0, 1'b1, 16'h4000, v, 1, st);
      st_sum += st;
    end
    chk("l0_stalls", 64'(st_sum), 64'd0);
    drain();

    // Reset mid-symbol at ph=3, then a fresh 8-sample symbol with cfg_l changed mid-emit
    send(32'h0010_0020, 1'b0, 5'd8, 1'b0, 16'h4000, 32'h0010_0020, 8, st);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    exp_q.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    chk("rst_mid_valid", 64'(out_valid), 64'd0);
    send(32'h0030_0040, 1'b1, 5'd8, 1'b0, 16'h4000, 32'h0030_0040, 8, st);
    cfg_l = 5'd2;
    drain();

    chk("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
